// File: rtl/water_sensor_conditioner.sv
// Synchronises, debounces and plausibility-checks the three float switches.
// Outputs update DEBOUNCE_CYCLES+3 edges after a steady raw change; a sticky fault forces 111.
module water_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FAULT_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_s0,
  input  logic       raw_s1,
  input  logic       raw_s2,
  input  logic       fault_clr,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [1:0] level,
  output logic       change,
  output logic       fault
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FW = (FAULT_CYCLES > 2) ? $clog2(FAULT_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FAULT_CYCLES - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [DW-1:0] db_cnt [3];
  logic [FW-1:0] flt_cnt;
  logic [2:0]    o_reg;

  logic       p_valid;
  logic       fault_set;
  logic [2:0] o_next;
  logic [1:0] level_next;

  always_comb begin
    p_valid   = (stable == 3'b000) || (stable == 3'b001) ||
                (stable == 3'b011) || (stable == 3'b111);
    fault_set = !p_valid && (flt_cnt == FLT_MAX);
    // A faulted sensor set reads as full so the pump stays off.
    if (fault)
      o_next = 3'b111;
    else if (p_valid)
      o_next = stable;
    else
      o_next = o_reg;
    case (o_next)
      3'b001:  level_next = 2'd1;
      3'b011:  level_next = 2'd2;
      3'b111:  level_next = 2'd3;
      default: level_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      flt_cnt <= '0;
      fault   <= 1'b0;
      o_reg   <= '0;
      level   <= '0;
      change  <= 1'b0;
    end else begin
      sync1 <= {raw_s2, raw_s1, raw_s0};
      sync2 <= sync1;

      // Any single agreeing cycle restarts the count, rejecting short glitches.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end

      if (p_valid)
        flt_cnt <= '0;
      else if (flt_cnt != FLT_MAX)
        flt_cnt <= flt_cnt + FW'(1);

      if (fault_set)
        fault <= 1'b1;
      else if (fault_clr && p_valid)
        fault <= 1'b0;

      o_reg  <= o_next;
      level  <= level_next;
      change <= (o_next != o_reg);
    end
  end

  assign s0 = o_reg[0];
  assign s1 = o_reg[1];
  assign s2 = o_reg[2];

endmodule
